// File: rtl/fault_countdown_ctrl.sv
// Fault/self-destruct controller: synchronises and debounces N fault switches plus an
// arm switch, votes K-of-N, runs an LED-bar countdown and pulses boom when it empties.

module fault_countdown_deb #(
    parameter int DEB_TICKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic sync_i,
    output logic nxt_o
);
    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (tick_i) begin
            if (sync_i != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_d = sync_i;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    // Exposes the level the debounced flop takes at this edge, so a consumer can act
    // in the same clock the debounced value changes.
    assign nxt_o = deb_d;
endmodule

module fault_countdown_ctrl #(
    parameter int TICK_DIV      = 250000,
    parameter int N_CH          = 4,
    parameter int K_VOTE        = 2,
    parameter int DEB_TICKS     = 3,
    parameter int STEP_TICKS    = 100,
    parameter int BLINK_TICKS   = 33,
    parameter int BAR_W         = 8,
    parameter int RELOAD_ON_CLR = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        arm_in,
    input  logic [N_CH-1:0]             fault_in,
    output logic [BAR_W-1:0]            leds,
    output logic [$clog2(N_CH+1)-1:0]   fault_count,
    output logic [1:0]                  state,
    output logic                        boom
);
    localparam int TW  = $clog2(TICK_DIV);
    localparam int FCW = $clog2(N_CH + 1);
    localparam int SW  = $clog2(STEP_TICKS + 1);
    localparam int BW  = $clog2(BLINK_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [BAR_W-1:0] ONES    = {BAR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_COUNT = 2'd2,
        S_DET   = 2'd3
    } state_t;

    logic [TW-1:0]    tick_cnt_q;
    logic             tick;
    logic [N_CH:0]    sync1_q, sync2_q, deb_nxt;
    logic [FCW-1:0]   fault_count_q, fault_count_d;
    logic             vote, arm_now;
    logic [BW-1:0]    blink_cnt_q;
    logic             phase_q;
    state_t           state_q, state_d;
    logic [BAR_W-1:0] bar_q, bar_d, bar_shift;
    logic [SW-1:0]    step_q, step_d;
    logic             boom_q, boom_d;
    logic [BAR_W-1:0] leds_q, leds_d;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            sync1_q    <= {arm_in, fault_in};
            sync2_q    <= sync1_q;
        end
    end

    // Channel N_CH is the arm switch; channels below it are the fault inputs.
    for (genvar g = 0; g <= N_CH; g++) begin : g_deb
        fault_countdown_deb #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick_i (tick),
            .sync_i (sync2_q[g]),
            .nxt_o  (deb_nxt[g])
        );
    end

    always_comb begin
        fault_count_d = '0;
        for (int i = 0; i < N_CH; i++)
            fault_count_d = fault_count_d + FCW'(deb_nxt[i]);
    end

    assign vote    = (fault_count_q >= FCW'(K_VOTE));
    assign arm_now = deb_nxt[N_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_count_q <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
        end else begin
            fault_count_q <= fault_count_d;
            if (tick) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
            end
        end
    end

    assign bar_shift = bar_q >> 1;

    always_comb begin
        state_d = state_q;
        bar_d   = bar_q;
        step_d  = step_q;
        boom_d  = 1'b0;
        if (!arm_now) begin
            state_d = S_IDLE;
            bar_d   = ONES;
            step_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARMED;
                S_ARMED: begin
                    if (vote) begin
                        state_d = S_COUNT;
                        step_d  = '0;
                        bar_d   = (RELOAD_ON_CLR != 0) ? ONES : bar_q;
                    end
                end
                S_COUNT: begin
                    // The emptying shift beats a simultaneous vote loss.
                    if (tick && step_q == STEP_LAST && bar_shift == '0) begin
                        state_d = S_DET;
                        bar_d   = '0;
                        step_d  = '0;
                        boom_d  = 1'b1;
                    end else if (!vote) begin
                        state_d = S_ARMED;
                        step_d  = '0;
                        if (RELOAD_ON_CLR != 0) bar_d = ONES;
                    end else if (tick) begin
                        if (step_q == STEP_LAST) begin
                            bar_d  = bar_shift;
                            step_d = '0;
                        end else begin
                            step_d = step_q + SW'(1);
                        end
                    end
                end
                S_DET:   state_d = S_DET;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        leds_d = ONES;
        case (state_q)
            S_IDLE:  leds_d = ONES;
            S_ARMED: leds_d = bar_q;
            S_COUNT: leds_d = phase_q ? '0 : bar_q;
            S_DET:   leds_d = phase_q ? '0 : ONES;
            default: leds_d = ONES;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bar_q   <= ONES;
            step_q  <= '0;
            boom_q  <= 1'b0;
            leds_q  <= ONES;
        end else begin
            state_q <= state_d;
            bar_q   <= bar_d;
            step_q  <= step_d;
            boom_q  <= boom_d;
            leds_q  <= leds_d;
        end
    end

    assign leds        = leds_q;
    assign fault_count = fault_count_q;
    assign state       = state_q;
    assign boom        = boom_q;
endmodule

// File: tb/tb_fault_countdown_ctrl.sv
// Directed bench: two instances (reload / hold on vote loss) share the same stimulus.

module tb_fault_countdown_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm_in = 1'b0;
    logic [3:0] fault_in = 4'b0;
    logic [7:0] leds_r, leds_h;
    logic [2:0] fc_r, fc_h;
    logic [1:0] st_r, st_h;
    logic       boom_r, boom_h;

    int tests = 0;
    int fails = 0;
    int nb_r = 0;
    int nb_h = 0;
    int n01 = 0;

    always #5 clk = ~clk;

    fault_countdown_ctrl #(
        .TICK_DIV(4), .N_CH(4), .K_VOTE(2), .DEB_TICKS(3), .STEP_TICKS(2),
        .BLINK_TICKS(1), .BAR_W(8), .RELOAD_ON_CLR(1)
    ) dut_r (
        .clk(clk), .rst_n(rst_n), .arm_in(arm_in), .fault_in(fault_in),
        .leds(leds_r), .fault_count(fc_r), .state(st_r), .boom(boom_r)
    );

    fault_countdown_ctrl #(
        .TICK_DIV(4), .N_CH(4), .K_VOTE(2), .DEB_TICKS(3), .STEP_TICKS(2),
        .BLINK_TICKS(1), .BAR_W(8), .RELOAD_ON_CLR(0)
    ) dut_h (
        .clk(clk), .rst_n(rst_n), .arm_in(arm_in), .fault_in(fault_in),
        .leds(leds_h), .fault_count(fc_h), .state(st_h), .boom(boom_h)
    );

    always @(negedge clk) begin
        if (boom_r) nb_r++;
        if (boom_h) nb_h++;
        if (st_r == 2'd2 && leds_r == 8'h01) n01++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_st(input bit use_h, input logic [1:0] s, input int max, input string tag);
        for (int i = 0; i < max && (use_h ? st_h : st_r) != s; i++) @(negedge clk);
        chk(tag, 32'(use_h ? st_h : st_r), 32'(s));
    endtask

    initial begin
        logic [7:0] seq[$];
        logic [7:0] exp_bar;
        int mx, b_r, b_h, c01;
        bit s_ff, s_00, s_oth;

        #12;
        chk("rst_state", 32'(st_r), 0);
        chk("rst_leds", 32'(leds_r), 'hFF);
        chk("rst_fc", 32'(fc_r), 0);
        chk("rst_boom", 32'(boom_r), 0);
        chk("rst_leds_h", 32'(leds_h), 'hFF);
        @(negedge clk) rst_n = 1'b1;
        cyc(3);

        arm_in = 1'b1;
        wait_st(0, 2'd1, 40, "arm_to_armed");
        cyc(2);
        chk("armed_leds", 32'(leds_r), 'hFF);

        // 8-clk (2-tick) glitch on fault 0 must not get through.
        mx = 0;
        fault_in[0] = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 8) fault_in[0] = 1'b0;
            @(negedge clk);
            if (int'(fc_r) > mx) mx = int'(fc_r);
        end
        chk("glitch_fc", 32'(mx), 0);
        chk("glitch_state", 32'(st_r), 1);

        fault_in[0] = 1'b1;
        cyc(20);
        chk("hold_fc", 32'(fc_r), 1);
        chk("hold_state", 32'(st_r), 1);

        // Full countdown to detonation.
        b_r = nb_r;
        b_h = nb_h;
        fault_in = 4'b0101;
        wait_st(0, 2'd2, 40, "vote_to_count");
        for (int i = 0; i < 200 && st_r != 2'd3; i++) begin
            if (leds_r != 8'h00 && (seq.size() == 0 || leds_r != seq[$])) seq.push_back(leds_r);
            @(negedge clk);
        end
        chk("det_state", 32'(st_r), 3);
        chk("seq_len", 32'(seq.size()), 8);
        exp_bar = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bar%0d", k), (k < seq.size()) ? 32'(seq[k]) : 32'hDEAD, 32'(exp_bar));
            exp_bar = exp_bar >> 1;
        end
        cyc(1);
        s_ff = 0; s_00 = 0; s_oth = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (leds_r == 8'hFF) s_ff = 1;
            else if (leds_r == 8'h00) s_00 = 1;
            else s_oth = 1;
        end
        chk("det_blink", 32'({s_ff, s_00, s_oth}), 'b110);
        chk("boom_once_r", 32'(nb_r - b_r), 1);
        chk("boom_once_h", 32'(nb_h - b_h), 1);
        chk("det_state_h", 32'(st_h), 3);

        // Detonated state ignores faults and leaves only on disarm.
        b_r = nb_r;
        b_h = nb_h;
        fault_in = 4'b0000;
        cyc(24);
        chk("det_sticky_0", 32'(st_r), 3);
        fault_in = 4'b1111;
        cyc(24);
        chk("fc_all", 32'(fc_r), 4);
        chk("det_sticky_f", 32'(st_r), 3);
        fault_in = 4'b0101;
        cyc(24);
        arm_in = 1'b0;
        wait_st(0, 2'd0, 40, "det_disarm");
        cyc(2);
        chk("disarm_leds", 32'(leds_r), 'hFF);
        chk("disarm_state_h", 32'(st_h), 0);
        chk("no_boom2_r", 32'(nb_r - b_r), 0);
        chk("no_boom2_h", 32'(nb_h - b_h), 0);

        // Vote loss mid-countdown: reload vs hold.
        arm_in = 1'b1;
        wait_st(0, 2'd2, 60, "rearm_count");
        for (int i = 0; i < 100 && leds_r != 8'h0F; i++) @(negedge clk);
        chk("see_0F", 32'(leds_r), 'h0F);
        fault_in = 4'b0001;
        wait_st(0, 2'd1, 40, "vote_drop");
        cyc(2);
        chk("reload_leds", 32'(leds_r), 'hFF);
        chk("hold_state_h", 32'(st_h), 1);
        chk("hold_leds_h", 32'(leds_h inside {8'h0F, 8'h07, 8'h03}), 1);

        // Resume: the held bar empties well before the reloaded one.
        fault_in = 4'b0101;
        wait_st(0, 2'd2, 60, "revote");
        wait_st(1, 2'd3, 100, "h_det_first");
        chk("r_still_count", 32'(st_r), 2);
        wait_st(0, 2'd3, 100, "r_det");

        // Debounced arm drop lands on the final-shift clock.
        arm_in = 1'b0;
        wait_st(0, 2'd0, 40, "t9_idle");
        cyc(4);
        chk("t9_idle_h", 32'(st_h), 0);
        b_r = nb_r;
        b_h = nb_h;
        c01 = n01;
        arm_in = 1'b1;
        wait_st(0, 2'd2, 60, "t9_count");
        repeat (51) @(posedge clk);
        @(negedge clk);
        arm_in = 1'b0;
        cyc(30);
        chk("t9_state", 32'(st_r), 0);
        chk("t9_state_h", 32'(st_h), 0);
        chk("t9_saw_01", 32'(n01 > c01), 1);
        chk("t9_noboom_r", 32'(nb_r - b_r), 0);
        chk("t9_noboom_h", 32'(nb_h - b_h), 0);

        // Async reset mid-countdown.
        arm_in = 1'b1;
        wait_st(0, 2'd2, 60, "t10_count");
        cyc(20);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(st_r), 0);
        chk("arst_leds", 32'(leds_r), 'hFF);
        chk("arst_boom", 32'(boom_r), 0);
        chk("arst_fc", 32'(fc_r), 0);
        chk("arst_fc_h", 32'(fc_h), 0);
        @(negedge clk) rst_n = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
